// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 16 x 16-bit register file with a per-register pending
// (scoreboard) bit. Writeback writes data and releases pending bits; decode
// marks destinations pending; operand reads are registered (1-cycle latency)
// and stall while any requested source is still pending.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write data is forwarded to an accepted read, so a
//               register written and released this cycle is readable at once.
//   undefined : reads always see stored contents; a pending register that is
//               being written this cycle still counts as a hazard, costing
//               one extra stall cycle.
module regfile_scoreboard #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          W_ON,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] DATA_IN,
  input  logic          ENDWRITE,
  input  logic [AW-1:0] ENDREG,
  input  logic          SET_BUSY,
  input  logic [AW-1:0] BUSY_ADDR,
  input  logic          RD_REQ,
  input  logic [AW-1:0] RADDR_A,
  input  logic [AW-1:0] RADDR_B,
  output logic [DW-1:0] RDATA_A,
  output logic [DW-1:0] RDATA_B,
  output logic          RD_VALID,
  output logic          STALL,
  output logic          BUSY_ERR
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic            haz_a;
  logic            haz_b;
  logic            accept;
  logic            busy_err_hit;
  logic [DW-1:0]   rd_a_next;
  logic [DW-1:0]   rd_b_next;

  // Per-source hazard: pending and not being released this very cycle.
  always_comb begin
    haz_a = pend[RADDR_A] && !(ENDWRITE && (ENDREG == RADDR_A));
    haz_b = pend[RADDR_B] && !(ENDWRITE && (ENDREG == RADDR_B));
`ifndef REGFILE_BYPASS_EN
    // Without forwarding the write must land first, so wait one more cycle.
    haz_a = haz_a || (pend[RADDR_A] && W_ON && (WADDR == RADDR_A));
    haz_b = haz_b || (pend[RADDR_B] && W_ON && (WADDR == RADDR_B));
`endif
  end

  assign STALL  = RD_REQ && (haz_a || haz_b);
  assign accept = RD_REQ && !(haz_a || haz_b);

  // Operand source selection, with optional write-through forwarding.
  always_comb begin
    rd_a_next = regs[RADDR_A];
    rd_b_next = regs[RADDR_B];
`ifdef REGFILE_BYPASS_EN
    if (W_ON && (WADDR == RADDR_A)) rd_a_next = DATA_IN;
    if (W_ON && (WADDR == RADDR_B)) rd_b_next = DATA_IN;
`endif
  end

  // Scoreboard update: release first, then set, so a new producer wins a collision.
  always_comb begin
    pend_next = pend;
    if (ENDWRITE) pend_next[ENDREG] = 1'b0;
    if (SET_BUSY) pend_next[BUSY_ADDR] = 1'b1;
    busy_err_hit = SET_BUSY && pend[BUSY_ADDR] && !(ENDWRITE && (ENDREG == BUSY_ADDR));
  end

  // Register array storage; every address including 0 is writable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (W_ON) begin
      regs[WADDR] <= DATA_IN;
    end
  end

  // Pending bits and the sticky double-issue error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend     <= '0;
      BUSY_ERR <= 1'b0;
    end else begin
      pend <= pend_next;
      if (busy_err_hit) BUSY_ERR <= 1'b1;
    end
  end

  // Registered operand outputs; data holds whenever no read is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDATA_A  <= '0;
      RDATA_B  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= accept;
      if (accept) begin
        RDATA_A <= rd_a_next;
        RDATA_B <= rd_b_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard. Accepted reads push their
// expected data and arrival cycle to a queue; a monitor pops and compares on
// every RD_VALID pulse. Honours REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        W_ON;
  logic [3:0]  WADDR;
  logic [15:0] DATA_IN;
  logic        ENDWRITE;
  logic [3:0]  ENDREG;
  logic        SET_BUSY;
  logic [3:0]  BUSY_ADDR;
  logic        RD_REQ;
  logic [3:0]  RADDR_A;
  logic [3:0]  RADDR_B;
  logic [15:0] RDATA_A;
  logic [15:0] RDATA_B;
  logic        RD_VALID;
  logic        STALL;
  logic        BUSY_ERR;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [15:0] last_a = 16'h0000;

  regfile_scoreboard dut (
    .CLK(CLK), .RST_N(RST_N), .W_ON(W_ON), .WADDR(WADDR), .DATA_IN(DATA_IN),
    .ENDWRITE(ENDWRITE), .ENDREG(ENDREG), .SET_BUSY(SET_BUSY), .BUSY_ADDR(BUSY_ADDR),
    .RD_REQ(RD_REQ), .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
    .RDATA_A(RDATA_A), .RDATA_B(RDATA_B), .RD_VALID(RD_VALID),
    .STALL(STALL), .BUSY_ERR(BUSY_ERR)
  );

  // Free-running clock and cycle counter used to tag expected read arrivals.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every RD_VALID pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && RD_VALID === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL rd_valid_unexpected cyc=%0d got valid=1 exp valid=0", cyc);
      end else begin
        mon_e = sb.pop_front();
        if ({RDATA_A, RDATA_B} !== {mon_e.a, mon_e.b} || cyc != mon_e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL rd_data got A=%h B=%h cyc=%0d exp A=%h B=%h cyc=%0d",
                   RDATA_A, RDATA_B, cyc, mon_e.a, mon_e.b, mon_e.cyc);
        end
      end
    end
  end

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drop every strobe.
  task automatic idle();
    W_ON = 1'b0; ENDWRITE = 1'b0; SET_BUSY = 1'b0; RD_REQ = 1'b0;
  endtask

  // Present a read for the coming edge and record what it must return.
  task automatic issue_read(input logic [3:0] a, input logic [3:0] b,
                            input logic [15:0] ea, input logic [15:0] eb);
    RD_REQ = 1'b1; RADDR_A = a; RADDR_B = b;
    sb.push_back('{ea, eb, cyc + 1});
    last_a = ea;
  endtask

  // Let outstanding reads arrive, then confirm none went missing.
  task automatic drain(input string name);
    idle();
    repeat (2) tick();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_missing_valid got %0d pending exp 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; idle();
    WADDR = '0; DATA_IN = '0; ENDREG = '0; BUSY_ADDR = '0; RADDR_A = '0; RADDR_B = '0;
    #12 RST_N = 1'b1;
    tick();
    tests_run++;
    if ({RDATA_A, RDATA_B, RD_VALID, STALL, BUSY_ERR} !== 35'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got A=%h B=%h v=%b s=%b e=%b exp all 0",
               RDATA_A, RDATA_B, RD_VALID, STALL, BUSY_ERR);
    end
    W_ON = 1'b1; WADDR = 4'd0; DATA_IN = 16'hFFFF; tick();
    WADDR = 4'd15; tick();
    W_ON = 1'b0; issue_read(4'd0, 4'd15, 16'hFFFF, 16'hFFFF); tick();
    RD_REQ = 1'b0; SET_BUSY = 1'b1; BUSY_ADDR = 4'd4; tick();
    tick();
    SET_BUSY = 1'b0;
    RD_REQ = 1'b1; RADDR_A = 4'd4; RADDR_B = 4'd4;
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b1 || BUSY_ERR !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_stall got stall=%b err=%b exp 1 1", STALL, BUSY_ERR);
    end
    #1 RST_N = 1'b0;
    #1;
    tests_run++;
    if ({RDATA_A, RDATA_B, RD_VALID, STALL, BUSY_ERR} !== 35'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got A=%h B=%h v=%b s=%b e=%b exp all 0",
               RDATA_A, RDATA_B, RD_VALID, STALL, BUSY_ERR);
    end
    RD_REQ = 1'b0;
    #1 RST_N = 1'b1;
    tick();
    issue_read(4'd0, 4'd15, 16'h0000, 16'h0000); tick();
    drain("reset");
  endtask

  task automatic test_basic();
    W_ON = 1'b1; WADDR = 4'd3; DATA_IN = 16'h1234; tick();
    WADDR = 4'd7; DATA_IN = 16'hBEEF; tick();
    WADDR = 4'd0; DATA_IN = 16'h0A0A; tick();
    W_ON = 1'b0; issue_read(4'd3, 4'd7, 16'h1234, 16'hBEEF); tick();
    RD_REQ = 1'b0; W_ON = 1'b1; WADDR = 4'd3; DATA_IN = 16'h5555; tick();
    W_ON = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (RDATA_A !== 16'h1234 || RD_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold got A=%h v=%b exp A=1234 v=0", RDATA_A, RD_VALID);
    end
    tick();
    issue_read(4'd0, 4'd0, 16'h0A0A, 16'h0A0A); tick();
    issue_read(4'd3, 4'd3, 16'h5555, 16'h5555); tick();
    W_ON = 1'b1; WADDR = 4'd7; DATA_IN = 16'h1111;
`ifdef REGFILE_BYPASS_EN
    issue_read(4'd7, 4'd3, 16'h1111, 16'h5555);
`else
    issue_read(4'd7, 4'd3, 16'hBEEF, 16'h5555);
`endif
    tick();
    W_ON = 1'b0; issue_read(4'd7, 4'd7, 16'h1111, 16'h1111); tick();
    drain("basic");
  endtask

  task automatic test_hazard();
    SET_BUSY = 1'b1; BUSY_ADDR = 4'd5; tick();
    SET_BUSY = 1'b0;
    RD_REQ = 1'b1; RADDR_A = 4'd5; RADDR_B = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests_run++;
      if (STALL !== 1'b1 || RDATA_A !== last_a) begin
        tests_failed++;
        $display("[TB] FAIL hazard_stall_%0d got stall=%b A=%h exp stall=1 A=%h",
                 i, STALL, RDATA_A, last_a);
      end
      tick();
    end
    W_ON = 1'b1; WADDR = 4'd5; DATA_IN = 16'h00A5; ENDWRITE = 1'b1; ENDREG = 4'd5;
`ifndef REGFILE_BYPASS_EN
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hazard_extra_stall got stall=%b exp 1", STALL);
    end
    tick();
    W_ON = 1'b0; ENDWRITE = 1'b0;
`endif
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hazard_release got stall=%b exp 0", STALL);
    end
    sb.push_back('{16'h00A5, 16'h0000, cyc + 1});
    last_a = 16'h0000;
    tick();
    drain("hazard_a");
    W_ON = 1'b1; WADDR = 4'd6; DATA_IN = 16'h0066; tick();
    W_ON = 1'b0; SET_BUSY = 1'b1; BUSY_ADDR = 4'd6; tick();
    SET_BUSY = 1'b0; RD_REQ = 1'b1; RADDR_A = 4'd1; RADDR_B = 4'd6;
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hazard_b_stall got stall=%b exp 1", STALL);
    end
    tick();
    ENDWRITE = 1'b1; ENDREG = 4'd6;
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hazard_b_release got stall=%b exp 0", STALL);
    end
    sb.push_back('{16'h0000, 16'h0066, cyc + 1});
    tick();
    drain("hazard_b");
  endtask

  task automatic test_collision();
    SET_BUSY = 1'b1; BUSY_ADDR = 4'd2; ENDWRITE = 1'b1; ENDREG = 4'd2; tick();
    idle();
    RD_REQ = 1'b1; RADDR_A = 4'd2; RADDR_B = 4'd2;
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b1 || BUSY_ERR !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL collision got stall=%b err=%b exp stall=1 err=0", STALL, BUSY_ERR);
    end
    tick();
    ENDWRITE = 1'b1; ENDREG = 4'd2;
    @(negedge CLK);
    tests_run++;
    if (STALL !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL collision_release got stall=%b exp 0", STALL);
    end
    sb.push_back('{16'h0000, 16'h0000, cyc + 1});
    tick();
    drain("collision");
  endtask

  task automatic test_back_to_back();
    W_ON = 1'b1; WADDR = 4'd1; DATA_IN = 16'h1111; tick();
    WADDR = 4'd2; DATA_IN = 16'h2222; tick();
    W_ON = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) issue_read(4'd1, 4'd2, 16'h1111, 16'h2222);
      else            issue_read(4'd2, 4'd1, 16'h2222, 16'h1111);
      @(negedge CLK);
      tests_run++;
      if (STALL !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL throughput_stall_%0d got stall=%b exp 0", i, STALL);
      end
      tick();
    end
    drain("throughput");
  endtask

  task automatic test_double_issue();
    SET_BUSY = 1'b1; BUSY_ADDR = 4'd9; tick();
    tests_run++;
    if (BUSY_ERR !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_issue_err got %b exp 0", BUSY_ERR);
    end
    tick();
    SET_BUSY = 1'b0;
    tests_run++;
    if (BUSY_ERR !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL double_issue_err got %b exp 1", BUSY_ERR);
    end
    ENDWRITE = 1'b1; ENDREG = 4'd9; tick();
    ENDWRITE = 1'b0;
    tests_run++;
    if (BUSY_ERR !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky got %b exp 1", BUSY_ERR);
    end
    issue_read(4'd9, 4'd9, 16'h0000, 16'h0000); tick();
    drain("double_issue");
    RST_N = 1'b0; #2 RST_N = 1'b1;
    tick();
    tests_run++;
    if (BUSY_ERR !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_reset got %b exp 0", BUSY_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_collision();
    test_back_to_back();
    test_double_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
